// File: rtl/reorder_buffer.sv
// -----------------------------------------------------------------------------
// reorder_buffer
//
// 16-entry circular reorder buffer sitting between decode/issue and the
// architectural register file. Each issued instruction gets a tag (the tail
// slot), and its destination register is renamed to that tag. CDB results are
// captured into their entries. Entries retire strictly in program order from
// the head, and each retirement writes the register file. A mispredicted
// branch that reaches the head flushes the whole buffer and redirects fetch.
//
// Optional feature (macro ROB_CDB_BYPASS_EN):
//   When defined, operand queries also see a CDB broadcast in the same cycle.
//   Commit never uses the bypass; it always needs the registered done bit.
//   When undefined, queries see registered state only.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-low reset
//   rdy             global enable; when low, all state holds
//   issue_*         instruction presented by decode; issue_ready/issue_tag back
//   rd_in_*         rename strobe, register and tag sent to the register file
//   cdb_*           result broadcast (tag, value, mispredict, target)
//   q1_*, q2_*      operand tag queries: ready flag and value (0 if not ready)
//   rd_out_*        commit strobe, register, value and tag (head)
//   flush, flush_pc registered one-cycle redirect pulse and its target PC
// -----------------------------------------------------------------------------
module reorder_buffer #(
  parameter int ROB_DEPTH = 16,
  parameter int TAG_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  // issue
  input  logic             issue_valid,
  input  logic             issue_has_rd,
  input  logic [4:0]       issue_rd,
  input  logic             issue_is_br,
  output logic             issue_ready,
  output logic [TAG_W-1:0] issue_tag,
  // rename
  output logic             rd_in_flag,
  output logic [4:0]       rd_in_a,
  output logic [TAG_W-1:0] rd_in_rob,
  // common data bus
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_val,
  input  logic             cdb_mispred,
  input  logic [31:0]      cdb_target,
  // operand queries
  input  logic [TAG_W-1:0] q1_tag,
  input  logic [TAG_W-1:0] q2_tag,
  output logic             q1_ready,
  output logic             q2_ready,
  output logic [31:0]      q1_val,
  output logic [31:0]      q2_val,
  // commit
  output logic             rd_out_flag,
  output logic [4:0]       rd_out_a,
  output logic [31:0]      rd_out_val,
  output logic [TAG_W-1:0] rd_out_rob,
  // redirect
  output logic             flush,
  output logic [31:0]      flush_pc
);

  localparam logic [TAG_W:0] FULL_COUNT = (TAG_W+1)'(ROB_DEPTH);

  // Control state, reset.
  logic [ROB_DEPTH-1:0] r_busy;
  logic [ROB_DEPTH-1:0] r_done;
  logic [TAG_W-1:0]     r_head;
  logic [TAG_W-1:0]     r_tail;
  logic [TAG_W:0]       r_count;
  logic                 r_flush;
  logic [31:0]          r_flush_pc;

  // Entry payload, not reset.
  logic                 r_has_rd  [ROB_DEPTH];
  logic [4:0]           r_rd      [ROB_DEPTH];
  logic                 r_is_br   [ROB_DEPTH];
  logic [31:0]          r_val     [ROB_DEPTH];
  logic                 r_mispred [ROB_DEPTH];
  logic [31:0]          r_target  [ROB_DEPTH];

  logic w_full;
  logic w_accept;
  logic w_commit;
  logic w_flush_commit;
  logic w_cdb_wr;

  // Full comes from the registered count, so a same-cycle commit does not
  // open a slot for issue.
  assign w_full      = (r_count == FULL_COUNT);
  assign issue_ready = !w_full && !r_flush;
  assign w_accept    = issue_valid && issue_ready && rdy;
  assign issue_tag   = r_tail;

  assign w_commit       = rdy && r_busy[r_head] && r_done[r_head] && !r_flush;
  assign w_flush_commit = w_commit && r_is_br[r_head] && r_mispred[r_head];
  assign w_cdb_wr       = rdy && cdb_valid && r_busy[cdb_tag];

  // Rename strobe; x0 is never renamed.
  assign rd_in_flag = w_accept && issue_has_rd && (issue_rd != 5'd0);
  assign rd_in_a    = issue_rd;
  assign rd_in_rob  = r_tail;

  // Commit outputs; the link register of a mispredicted JAL/JALR still commits.
  assign rd_out_flag = w_commit && r_has_rd[r_head] && (r_rd[r_head] != 5'd0);
  assign rd_out_a    = w_commit ? r_rd[r_head]  : 5'd0;
  assign rd_out_val  = w_commit ? r_val[r_head] : 32'd0;
  assign rd_out_rob  = r_head;

  assign flush    = r_flush;
  assign flush_pc = r_flush_pc;

  // Operand lookup: {ready, value}; value reads 0 when not ready.
  function automatic logic [32:0] query(input logic [TAG_W-1:0] tag);
    logic        ready;
    logic [31:0] val;
    ready = r_busy[tag] && r_done[tag];
    val   = ready ? r_val[tag] : 32'd0;
`ifdef ROB_CDB_BYPASS_EN
    if (cdb_valid && (cdb_tag == tag) && r_busy[tag]) begin
      ready = 1'b1;
      val   = cdb_val;
    end
`endif
    return {ready, val};
  endfunction

  always_comb begin
    {q1_ready, q1_val} = query(q1_tag);
    {q2_ready, q2_val} = query(q2_tag);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy     <= '0;
      r_done     <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_flush    <= 1'b0;
      r_flush_pc <= 32'd0;
    end else if (rdy) begin
      if (w_flush_commit) begin
        // Mispredict at the head: drop everything, including any same-cycle issue.
        r_busy  <= '0;
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_accept) begin
          r_busy[r_tail] <= 1'b1;
          r_done[r_tail] <= 1'b0;
          r_tail         <= r_tail + 1'b1;
        end
        if (w_commit) begin
          r_busy[r_head] <= 1'b0;
          r_head         <= r_head + 1'b1;
        end
        case ({w_accept, w_commit})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
      // An accepted issue never targets a busy slot, so this cannot collide
      // with the done clear above.
      if (w_cdb_wr) begin
        r_done[cdb_tag] <= 1'b1;
      end
      r_flush <= w_flush_commit;
      if (w_flush_commit) begin
        r_flush_pc <= r_target[r_head];
      end
    end
  end

  // NOTE: payload storage has no reset; busy/done gate every use of it, and
  // leaving the arrays unreset lets them map onto plain register-file storage.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_has_rd[r_tail] <= issue_has_rd;
      r_rd[r_tail]     <= issue_rd;
      r_is_br[r_tail]  <= issue_is_br;
    end
    if (w_cdb_wr) begin
      r_val[cdb_tag]     <= cdb_val;
      r_mispred[cdb_tag] <= cdb_mispred;
      r_target[cdb_tag]  <= cdb_target;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// -----------------------------------------------------------------------------
// tb_reorder_buffer
//
// Directed test of reorder_buffer: reset state, rename/commit of a single
// instruction, full buffer and wrap, out-of-order completion with in-order
// retirement, mispredict flush, rdy stall and the optional CDB query bypass
// (expectations follow ROB_CDB_BYPASS_EN when it is defined).
// Inputs change 1 time unit after the rising edge; outputs are checked 2 time
// units after the edge, well before the next one.
// -----------------------------------------------------------------------------
module tb_reorder_buffer;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        issue_valid;
  logic        issue_has_rd;
  logic [4:0]  issue_rd;
  logic        issue_is_br;
  logic        issue_ready;
  logic [3:0]  issue_tag;
  logic        rd_in_flag;
  logic [4:0]  rd_in_a;
  logic [3:0]  rd_in_rob;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_val;
  logic        cdb_mispred;
  logic [31:0] cdb_target;
  logic [3:0]  q1_tag;
  logic [3:0]  q2_tag;
  logic        q1_ready;
  logic        q2_ready;
  logic [31:0] q1_val;
  logic [31:0] q2_val;
  logic        rd_out_flag;
  logic [4:0]  rd_out_a;
  logic [31:0] rd_out_val;
  logic [3:0]  rd_out_rob;
  logic        flush;
  logic [31:0] flush_pc;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef ROB_CDB_BYPASS_EN
  localparam logic BYPASS = 1'b1;
`else
  localparam logic BYPASS = 1'b0;
`endif

  reorder_buffer dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .issue_valid  (issue_valid),
    .issue_has_rd (issue_has_rd),
    .issue_rd     (issue_rd),
    .issue_is_br  (issue_is_br),
    .issue_ready  (issue_ready),
    .issue_tag    (issue_tag),
    .rd_in_flag   (rd_in_flag),
    .rd_in_a      (rd_in_a),
    .rd_in_rob    (rd_in_rob),
    .cdb_valid    (cdb_valid),
    .cdb_tag      (cdb_tag),
    .cdb_val      (cdb_val),
    .cdb_mispred  (cdb_mispred),
    .cdb_target   (cdb_target),
    .q1_tag       (q1_tag),
    .q2_tag       (q2_tag),
    .q1_ready     (q1_ready),
    .q2_ready     (q2_ready),
    .q1_val       (q1_val),
    .q2_val       (q2_val),
    .rd_out_flag  (rd_out_flag),
    .rd_out_a     (rd_out_a),
    .rd_out_val   (rd_out_val),
    .rd_out_rob   (rd_out_rob),
    .flush        (flush),
    .flush_pc     (flush_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    issue_valid  = 1'b0;
    issue_has_rd = 1'b0;
    issue_rd     = 5'd0;
    issue_is_br  = 1'b0;
    cdb_valid    = 1'b0;
    cdb_tag      = 4'd0;
    cdb_val      = 32'd0;
    cdb_mispred  = 1'b0;
    cdb_target   = 32'd0;
  endtask

  task automatic set_issue(input logic [4:0] rd, input logic has_rd, input logic is_br);
    issue_valid  = 1'b1;
    issue_rd     = rd;
    issue_has_rd = has_rd;
    issue_is_br  = is_br;
  endtask

  task automatic set_cdb(input logic [3:0] tag, input logic [31:0] val,
                         input logic mispred, input logic [31:0] target);
    cdb_valid   = 1'b1;
    cdb_tag     = tag;
    cdb_val     = val;
    cdb_mispred = mispred;
    cdb_target  = target;
  endtask

  task automatic do_reset();
    clear_inputs();
    rdy    = 1'b1;
    q1_tag = 4'd0;
    q2_tag = 4'd0;
    rst    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
  endtask

  initial begin
    // ---------------- reset then idle ----------------
    do_reset();
    check("rst_issue_ready", 32'(issue_ready), 32'd1);
    check("rst_issue_tag",   32'(issue_tag),   32'd0);
    check("rst_rd_in_flag",  32'(rd_in_flag),  32'd0);
    check("rst_rd_out_flag", 32'(rd_out_flag), 32'd0);
    check("rst_flush",       32'(flush),       32'd0);
    check("rst_flush_pc",    flush_pc,         32'd0);
    for (int t = 0; t < 16; t++) begin
      q1_tag = 4'(t);
      #1;
      check($sformatf("rst_q1_ready_t%0d", t), 32'(q1_ready), 32'd0);
    end
    q1_tag = 4'd0;

    // ---------------- issue x5, complete, commit ----------------
    set_issue(5'd5, 1'b1, 1'b0);
    #1;
    check("iss_rd_in_flag", 32'(rd_in_flag), 32'd1);
    check("iss_rd_in_a",    32'(rd_in_a),    32'd5);
    check("iss_rd_in_rob",  32'(rd_in_rob),  32'd0);
    step();
    clear_inputs();
    #1;
    check("iss_tag_after",  32'(issue_tag),  32'd1);
    check("iss_q1_notdone", 32'(q1_ready),   32'd0);
    set_cdb(4'd0, 32'h1234, 1'b0, 32'd0);
    #1;
    check("cdb_q1_same_ready", 32'(q1_ready), 32'(BYPASS));
    check("cdb_q1_same_val",   q1_val,        BYPASS ? 32'h1234 : 32'd0);
    check("cdb_no_early_commit", 32'(rd_out_flag), 32'd0);
    step();
    clear_inputs();
    #1;
    check("cdb_q1_ready",    32'(q1_ready),    32'd1);
    check("cdb_q1_val",      q1_val,           32'h1234);
    check("cmt_rd_out_flag", 32'(rd_out_flag), 32'd1);
    check("cmt_rd_out_a",    32'(rd_out_a),    32'd5);
    check("cmt_rd_out_val",  rd_out_val,       32'h1234);
    check("cmt_rd_out_rob",  32'(rd_out_rob),  32'd0);
    step();
    check("cmt_head_adv",    32'(rd_out_rob),  32'd1);
    check("cmt_q1_retired",  32'(q1_ready),    32'd0);

    // ---------------- fill all 16 entries ----------------
    do_reset();
    for (int i = 0; i < 16; i++) begin
      set_issue(5'(i + 1), 1'b1, 1'b0);
      #1;
      check($sformatf("fill_tag_%0d", i), 32'(issue_tag), 32'(i));
      step();
    end
    clear_inputs();
    #1;
    check("full_issue_ready", 32'(issue_ready), 32'd0);
    check("full_tail_wrap",   32'(issue_tag),   32'd0);
    set_issue(5'd20, 1'b1, 1'b0);
    #1;
    check("full_17th_no_rename", 32'(rd_in_flag), 32'd0);
    step();
    clear_inputs();
    #1;
    check("full_17th_tail", 32'(issue_tag), 32'd0);
    set_cdb(4'd0, 32'h0000_00A0, 1'b0, 32'd0);
    #1;
    step();
    clear_inputs();
    #1;
    check("full_cmt_flag",      32'(rd_out_flag), 32'd1);
    check("full_cmt_a",         32'(rd_out_a),    32'd1);
    check("full_cmt_val",       rd_out_val,       32'h0000_00A0);
    check("full_cmt_same_cyc",  32'(issue_ready), 32'd0);
    step();
    check("full_ready_after",   32'(issue_ready), 32'd1);
    check("full_tag_after",     32'(issue_tag),   32'd0);
    check("full_head_after",    32'(rd_out_rob),  32'd1);
    check("full_no_cmt_head1",  32'(rd_out_flag), 32'd0);

    // ---------------- out-of-order completion ----------------
    do_reset();
    set_issue(5'd7, 1'b1, 1'b0);
    step();
    set_issue(5'd8, 1'b1, 1'b0);
    step();
    set_issue(5'd0, 1'b1, 1'b0);
    #1;
    check("ooo_x0_no_rename", 32'(rd_in_flag), 32'd0);
    step();
    clear_inputs();
    set_cdb(4'd2, 32'h22, 1'b0, 32'd0);
    #1;
    step();
    set_cdb(4'd1, 32'h11, 1'b0, 32'd0);
    #1;
    check("ooo_no_cmt_after2", 32'(rd_out_flag), 32'd0);
    step();
    set_cdb(4'd0, 32'h77, 1'b0, 32'd0);
    #1;
    check("ooo_no_cmt_after1", 32'(rd_out_flag), 32'd0);
    step();
    clear_inputs();
    #1;
    check("ooo_cmt0_flag", 32'(rd_out_flag), 32'd1);
    check("ooo_cmt0_rob",  32'(rd_out_rob),  32'd0);
    check("ooo_cmt0_a",    32'(rd_out_a),    32'd7);
    check("ooo_cmt0_val",  rd_out_val,       32'h77);
    step();
    check("ooo_cmt1_flag", 32'(rd_out_flag), 32'd1);
    check("ooo_cmt1_rob",  32'(rd_out_rob),  32'd1);
    check("ooo_cmt1_a",    32'(rd_out_a),    32'd8);
    check("ooo_cmt1_val",  rd_out_val,       32'h11);
    step();
    check("ooo_cmt2_x0_flag", 32'(rd_out_flag), 32'd0);
    check("ooo_cmt2_rob",     32'(rd_out_rob),  32'd2);
    step();
    check("ooo_head_after",   32'(rd_out_rob),  32'd3);

    // ---------------- mispredict flush ----------------
    do_reset();
    for (int i = 0; i < 7; i++) begin
      if (i == 3) set_issue(5'd1, 1'b1, 1'b1);
      else        set_issue(5'(i + 2), 1'b1, 1'b0);
      step();
    end
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      set_cdb(4'(i), 32'h10 + 32'(i), 1'b0, 32'd0);
      step();
    end
    clear_inputs();
    step();
    step();
    check("mp_head_at_br", 32'(rd_out_rob),  32'd3);
    check("mp_br_pending", 32'(rd_out_flag), 32'd0);
    check("mp_tail",       32'(issue_tag),   32'd7);
    set_cdb(4'd3, 32'h44, 1'b1, 32'h0000_1000);
    #1;
    step();
    clear_inputs();
    set_issue(5'd9, 1'b1, 1'b0);
    #1;
    check("mp_link_flag",   32'(rd_out_flag), 32'd1);
    check("mp_link_a",      32'(rd_out_a),    32'd1);
    check("mp_link_val",    rd_out_val,       32'h44);
    check("mp_flush_early", 32'(flush),       32'd0);
    step();
    clear_inputs();
    q1_tag = 4'd4;
    #1;
    check("mp_flush",         32'(flush),       32'd1);
    check("mp_flush_pc",      flush_pc,         32'h0000_1000);
    check("mp_flush_nrdy",    32'(issue_ready), 32'd0);
    check("mp_flush_tail",    32'(issue_tag),   32'd0);
    check("mp_flush_head",    32'(rd_out_rob),  32'd0);
    check("mp_flush_no_cmt",  32'(rd_out_flag), 32'd0);
    check("mp_q_tag4_gone",   32'(q1_ready),    32'd0);
    step();
    check("mp_flush_drop",    32'(flush),       32'd0);
    check("mp_ready_again",   32'(issue_ready), 32'd1);
    check("mp_dropped_issue", 32'(issue_tag),   32'd0);
    q1_tag = 4'd0;

    // ---------------- rdy low stalls everything ----------------
    set_issue(5'd10, 1'b1, 1'b0);
    step();
    clear_inputs();
    rdy = 1'b0;
    set_cdb(4'd0, 32'h55, 1'b0, 32'd0);
    set_issue(5'd11, 1'b1, 1'b0);
    #1;
    check("rdy_no_rename", 32'(rd_in_flag), 32'd0);
    step();
    clear_inputs();
    #1;
    check("rdy_no_capture", 32'(q1_ready),  32'd0);
    check("rdy_no_issue",   32'(issue_tag), 32'd1);
    rdy = 1'b1;
    set_cdb(4'd0, 32'h55, 1'b0, 32'd0);
    step();
    clear_inputs();
    #1;
    check("rdy_capture",     32'(q1_ready),    32'd1);
    check("rdy_capture_val", q1_val,           32'h55);
    check("rdy_cmt_ready",   32'(rd_out_flag), 32'd1);
    rdy = 1'b0;
    #1;
    check("rdy_low_no_cmt",  32'(rd_out_flag), 32'd0);
    step();
    check("rdy_low_head",    32'(rd_out_rob),  32'd0);
    rdy = 1'b1;
    #1;
    check("rdy_resume_flag", 32'(rd_out_flag), 32'd1);
    check("rdy_resume_a",    32'(rd_out_a),    32'd10);
    step();
    check("rdy_resume_head", 32'(rd_out_rob),  32'd1);

    // ---------------- query bypass on tag 7 ----------------
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_issue(5'(i + 1), 1'b1, 1'b0);
      step();
    end
    clear_inputs();
    q2_tag = 4'd7;
    set_cdb(4'd7, 32'h0000_CAFE, 1'b0, 32'd0);
    #1;
    check("byp_q2_ready_same", 32'(q2_ready), 32'(BYPASS));
    check("byp_q2_val_same",   q2_val,        BYPASS ? 32'h0000_CAFE : 32'd0);
    check("byp_no_cmt_bypass", 32'(rd_out_flag), 32'd0);
    step();
    clear_inputs();
    #1;
    check("byp_q2_ready_next", 32'(q2_ready), 32'd1);
    check("byp_q2_val_next",   q2_val,        32'h0000_CAFE);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
